// File: rtl/prop_loop_mon_pkg.sv
// Package: prop_loop_mon_pkg
// Purpose: shared types and constants for the propagation-loop monitor.
//   mon_state_e : monitor FSM states
//   STAMP_W     : width of the optional free-running cycle stamp
//                 (used only when PROP_LOOP_MON_STAMP_EN is defined)
package prop_loop_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_COUNT  = 3'd2,
    ST_REPORT = 3'd3,
    ST_TRIP   = 3'd4
  } mon_state_e;

  localparam int unsigned STAMP_W = 32;

endpackage

// File: rtl/prop_loop_chg_det.sv
// Module: prop_loop_chg_det
// Purpose: registers the watched vector every cycle, flags a masked change
//          against the previous sample and keeps a saturating change count.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   i_sig       : watched vector
//   i_mask      : 1 = bit participates in change detection
//   i_det_en    : change detection qualifier (monitor is counting)
//   i_cnt_clr   : zero the change counter (has priority over increment)
//   o_chg_c     : combinational masked-change flag for the current cycle
//   o_chg_cnt   : registered change count
module prop_loop_chg_det
  import prop_loop_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_sig,
  input  logic [WIDTH-1:0] i_mask,
  input  logic             i_det_en,
  input  logic             i_cnt_clr,
  output logic             o_chg_c,
  output logic [CNT_W-1:0] o_chg_cnt
);

  logic [WIDTH-1:0] r_sig_q;
  logic [CNT_W-1:0] r_chg_cnt;
  logic             w_chg;

  assign w_chg = i_det_en & (|((i_sig ^ r_sig_q) & i_mask));

  // Sample register and saturating counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig_q   <= '0;
      r_chg_cnt <= '0;
    end else begin
      r_sig_q <= i_sig;
      if (i_cnt_clr) begin
        r_chg_cnt <= '0;
      end else if (w_chg && (r_chg_cnt != '1)) begin
        r_chg_cnt <= r_chg_cnt + CNT_W'(1);
      end
    end
  end

  assign o_chg_c   = w_chg;
  assign o_chg_cnt = r_chg_cnt;

endmodule

// File: rtl/prop_loop_monitor.sv
// Module: prop_loop_monitor
// Purpose: observes a self-retriggering update loop; counts masked changes of
//          sig per WINDOW-cycle window, reports each window's count over a
//          valid/ready handshake and latches a sticky trip when a window
//          reaches THRESH changes.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : monitor enable
//   clear       : clear trip / abort, return to idle
//   sig, mask   : watched vector and participating-bit mask
//   rpt_valid   : window report available (held until rpt_ready)
//   rpt_ready   : report consumer ready
//   rpt_count   : changes seen in the reported window
//   rpt_last    : sig sample at the window's final cycle
//   tripped     : sticky loop-detected flag
//   trip_value  : sig sample on which the THRESH-th change was seen
//   trip_cycle  : cycle stamp of the trip edge (PROP_LOOP_MON_STAMP_EN only)
// Build option: define PROP_LOOP_MON_STAMP_EN to add the free-running cycle
//   counter and the trip_cycle port.
module prop_loop_monitor
  import prop_loop_mon_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned WINDOW = 16,
  parameter  int unsigned THRESH = 4,
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] sig,
  input  logic [WIDTH-1:0] mask,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic [WIDTH-1:0] rpt_last,
  output logic             tripped,
  output logic [WIDTH-1:0] trip_value
`ifdef PROP_LOOP_MON_STAMP_EN
  ,
  output logic [STAMP_W-1:0] trip_cycle
`endif
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] TRIP_AT  = CNT_W'(THRESH - 1);

  mon_state_e       r_state;
  logic [CNT_W-1:0] r_win_cnt;
  logic             r_rpt_valid;
  logic [CNT_W-1:0] r_rpt_count;
  logic [WIDTH-1:0] r_rpt_last;
  logic             r_tripped;
  logic [WIDTH-1:0] r_trip_value;

  logic             w_chg;
  logic [CNT_W-1:0] w_chg_cnt;
  logic             w_trip;
  logic [CNT_W-1:0] w_final_cnt;

  prop_loop_chg_det #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_chg_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sig     (sig),
    .i_mask    (mask),
    .i_det_en  (r_state == ST_COUNT),
    .i_cnt_clr (r_state == ST_PRIME),
    .o_chg_c   (w_chg),
    .o_chg_cnt (w_chg_cnt)
  );

  // The counter still holds the pre-edge value, so the current change is added here
  assign w_trip      = w_chg && (w_chg_cnt == TRIP_AT);
  assign w_final_cnt = w_chg_cnt + CNT_W'(w_chg);

`ifdef PROP_LOOP_MON_STAMP_EN
  logic [STAMP_W-1:0] r_cycle;
  logic [STAMP_W-1:0] r_trip_cycle;

  // Free-running cycle stamp, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + STAMP_W'(1);
    end
  end

  assign trip_cycle = r_trip_cycle;
`endif

  // Monitor FSM with window counter, report and trip registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_win_cnt    <= '0;
      r_rpt_valid  <= 1'b0;
      r_rpt_count  <= '0;
      r_rpt_last   <= '0;
      r_tripped    <= 1'b0;
      r_trip_value <= '0;
`ifdef PROP_LOOP_MON_STAMP_EN
      r_trip_cycle <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!clear && en) begin
            r_state <= ST_PRIME;
          end
        end

        ST_PRIME: begin
          r_win_cnt <= '0;
          r_state   <= clear ? ST_IDLE : ST_COUNT;
        end

        // Disable/clear abandon the window before any trip or report decision
        ST_COUNT: begin
          if (clear || !en) begin
            r_state <= ST_IDLE;
          end else if (w_trip) begin
            r_tripped    <= 1'b1;
            r_trip_value <= sig;
`ifdef PROP_LOOP_MON_STAMP_EN
            r_trip_cycle <= r_cycle;
`endif
            r_state      <= ST_TRIP;
          end else if (r_win_cnt == WIN_LAST) begin
            r_rpt_valid <= 1'b1;
            r_rpt_count <= w_final_cnt;
            r_rpt_last  <= sig;
            r_state     <= ST_REPORT;
          end else begin
            r_win_cnt <= r_win_cnt + CNT_W'(1);
          end
        end

        ST_REPORT: begin
          if (clear) begin
            r_rpt_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (rpt_ready) begin
            r_rpt_valid <= 1'b0;
            r_state     <= en ? ST_PRIME : ST_IDLE;
          end
        end

        ST_TRIP: begin
          if (clear) begin
            r_tripped    <= 1'b0;
            r_trip_value <= '0;
`ifdef PROP_LOOP_MON_STAMP_EN
            r_trip_cycle <= '0;
`endif
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rpt_valid  = r_rpt_valid;
  assign rpt_count  = r_rpt_count;
  assign rpt_last   = r_rpt_last;
  assign tripped    = r_tripped;
  assign trip_value = r_trip_value;

endmodule

// File: tb/tb_prop_loop_monitor.sv
// Testbench: tb_prop_loop_monitor
// Directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a window-sample reference model.
module tb_prop_loop_monitor;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned WINDOW = 16;
  localparam int unsigned THRESH = 4;
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] mask;
  logic             rpt_ready;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_count;
  logic [WIDTH-1:0] rpt_last;
  logic             tripped;
  logic [WIDTH-1:0] trip_value;
`ifdef PROP_LOOP_MON_STAMP_EN
  logic [31:0]      trip_cycle;
`endif

  prop_loop_monitor #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW),
    .THRESH (THRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clear      (clear),
    .sig        (sig),
    .mask       (mask),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_count  (rpt_count),
    .rpt_last   (rpt_last),
    .tripped    (tripped),
    .trip_value (trip_value)
`ifdef PROP_LOOP_MON_STAMP_EN
    ,
    .trip_cycle (trip_cycle)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A window is the list of sig samples since priming; its change count is the
  // number of consecutive sample pairs that differ under the mask of the later one.
  typedef enum int {PH_OFF, PH_ARMING, PH_WATCH, PH_HOLD, PH_LATCHED} phase_t;
  phase_t           m_phase   = PH_OFF;
  logic [WIDTH-1:0] m_samples[$];
  int               m_changes = 0;
  bit               m_c;
  logic             m_valid   = 1'b0;
  logic [CNT_W-1:0] m_count   = '0;
  logic [WIDTH-1:0] m_last    = '0;
  logic             m_trip    = 1'b0;
  logic [WIDTH-1:0] m_tval    = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = PH_OFF; m_valid = 1'b0; m_count = '0; m_last = '0;
      m_trip = 1'b0; m_tval = '0; m_samples.delete(); m_changes = 0;
    end else begin
      case (m_phase)
        PH_OFF: if (!clear && en) m_phase = PH_ARMING;
        PH_ARMING: begin
          if (clear) m_phase = PH_OFF;
          else begin
            m_samples.delete();
            m_samples.push_back(sig);
            m_changes = 0;
            m_phase = PH_WATCH;
          end
        end
        PH_WATCH: begin
          if (clear || !en) m_phase = PH_OFF;
          else begin
            m_c = (((sig ^ m_samples[$]) & mask) != '0);
            m_samples.push_back(sig);
            if (m_c) m_changes++;
            if (m_c && m_changes == int'(THRESH)) begin
              m_trip = 1'b1; m_tval = sig; m_phase = PH_LATCHED;
            end else if (m_samples.size() == int'(WINDOW) + 1) begin
              m_valid = 1'b1; m_count = CNT_W'(m_changes); m_last = sig; m_phase = PH_HOLD;
            end
          end
        end
        PH_HOLD: begin
          if (clear) begin m_valid = 1'b0; m_phase = PH_OFF; end
          else if (rpt_ready) begin m_valid = 1'b0; m_phase = en ? PH_ARMING : PH_OFF; end
        end
        PH_LATCHED: begin
          if (clear) begin m_trip = 1'b0; m_tval = '0; m_phase = PH_OFF; end
        end
        default: m_phase = PH_OFF;
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("rpt_valid",  32'(rpt_valid),  32'(m_valid));
      chk("rpt_count",  32'(rpt_count),  32'(m_count));
      chk("rpt_last",   32'(rpt_last),   32'(m_last));
      chk("tripped",    32'(tripped),    32'(m_trip));
      chk("trip_value", 32'(trip_value), 32'(m_tval));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go_idle();
    en = 1'b0; clear = 1'b1; tick(); clear = 1'b0; tick();
  endtask

  // Counts edges until rpt_valid rises (bounded) and checks the count
  task automatic wait_valid(input string name, input int exp_edges);
    int k = 0;
    while (!rpt_valid && k < 40) begin
      tick();
      k++;
    end
    chk(name, 32'(k), 32'(exp_edges));
  endtask

  int mode = 0;

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; sig = '0; mask = '1; rpt_ready = 1'b0;
    tick();
    cmp_on = 1'b1;
    tick();
    chk("reset_valid",   32'(rpt_valid),  32'd0);
    chk("reset_tripped", 32'(tripped),    32'd0);
    chk("reset_tval",    32'(trip_value), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: constant sig, first report latency
    go_idle();
    mask = 16'hFFFF; sig = 16'h0000; rpt_ready = 1'b1; en = 1'b1;
    tick();
    wait_valid("t1_latency", 17);
    chk("t1_count", 32'(rpt_count), 32'd0);
    chk("t1_last",  32'(rpt_last),  32'h0000);

    // 2: loop emulation on bit 0 trips at value 4
    go_idle();
    mask = 16'h0001; sig = 16'h0000; en = 1'b1;
    tick(); tick();
    repeat (4) begin sig = sig + 16'd1; tick(); end
    chk("t2_tripped", 32'(tripped),    32'd1);
    chk("t2_tval",    32'(trip_value), 32'h0004);
    chk("t2_novalid", 32'(rpt_valid),  32'd0);
    en = 1'b0;
    repeat (20) begin sig = sig + 16'd1; tick(); end
    chk("t2_sticky", 32'(tripped),    32'd1);
    chk("t2_tval_hold", 32'(trip_value), 32'h0004);

    // 5: clear with en=1, then re-prime on the following edge
    sig = 16'h1234; en = 1'b1; clear = 1'b1;
    tick();
    chk("t5_tripped", 32'(tripped),    32'd0);
    chk("t5_tval",    32'(trip_value), 32'd0);
    clear = 1'b0;
    tick();
    wait_valid("t5_reprime", 17);
    chk("t5_count", 32'(rpt_count), 32'd0);

    // 3: masked-out toggling, then unmasked
    go_idle();
    mask = 16'h0001; sig = 16'h0000; en = 1'b1;
    tick();
    repeat (17) begin sig = sig ^ 16'h0100; tick(); end
    chk("t3_valid", 32'(rpt_valid), 32'd1);
    chk("t3_count", 32'(rpt_count), 32'd0);
    go_idle();
    mask = 16'hFFFF; sig = 16'h0000; en = 1'b1;
    tick();
    repeat (6) begin sig = sig ^ 16'h0100; tick(); end
    chk("t3_tripped", 32'(tripped),    32'd1);
    chk("t3_tval",    32'(trip_value), 32'h0100);

    // 4: three changes, report held under back-pressure
    go_idle();
    mask = 16'hFFFF; sig = 16'h0000; rpt_ready = 1'b0; en = 1'b1;
    tick(); tick();
    sig = 16'd1; tick();
    sig = 16'd2; tick();
    sig = 16'd3; tick();
    repeat (13) tick();
    chk("t4_valid", 32'(rpt_valid), 32'd1);
    chk("t4_count", 32'(rpt_count), 32'd3);
    chk("t4_last",  32'(rpt_last),  32'd3);
    repeat (5) begin
      sig = sig + 16'd7; tick();
      chk("t4_hold_valid", 32'(rpt_valid), 32'd1);
      chk("t4_hold_count", 32'(rpt_count), 32'd3);
      chk("t4_hold_last",  32'(rpt_last),  32'd3);
    end
    rpt_ready = 1'b1;
    tick();
    chk("t4_drop", 32'(rpt_valid), 32'd0);
    wait_valid("t4_next_latency", 17);
    chk("t4_next_count", 32'(rpt_count), 32'd0);

    // 6: reset mid-window with two changes counted
    go_idle();
    mask = 16'hFFFF; sig = 16'h0000; en = 1'b1;
    tick(); tick();
    sig = 16'd1; tick();
    sig = 16'd2; tick();
    rst_n = 1'b0;
    tick();
    chk("t6_valid",   32'(rpt_valid),  32'd0);
    chk("t6_count",   32'(rpt_count),  32'd0);
    chk("t6_last",    32'(rpt_last),   32'd0);
    chk("t6_tripped", 32'(tripped),    32'd0);
    chk("t6_tval",    32'(trip_value), 32'd0);
    rst_n = 1'b1;
    tick();
    wait_valid("t6_latency", 17);
    chk("t6_fresh_count", 32'(rpt_count), 32'd0);
    chk("t6_fresh_last",  32'(rpt_last),  32'd2);

    // Randomized traffic
    go_idle();
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: mask = 16'hFFFF;
          1: mask = 16'h0001;
          default: mask = 16'($urandom);
        endcase
      end
      rst_n     = ($urandom_range(0, 399) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      en        = ($urandom_range(0, 19) != 0);
      rpt_ready = ($urandom_range(0, 2) != 0);
      case (mode)
        0: sig = sig + 16'd1;
        1: if ($urandom_range(0, 7) == 0) sig = 16'($urandom);
        default: if ($urandom_range(0, 3) == 0) sig = sig ^ (16'd1 << $urandom_range(0, 15));
      endcase
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
